soc_bus_arbiter: RTL and testbench
==================================

// Module: soc_bus_arbiter
// PURPOSE
// - Shares the single SoC slave bus (ROM/NVRAM/RAM/UART decode) between two masters: M0 = CPU, M1 = DMA/debug.
// - Round-robin grant, one transaction at a time, slave wait states via s_rdy.
// - Bus-error timeout when a slave never asserts rdy.
// - Sits between the masters and the existing address decoder/data mux; the decoder is unchanged.
// PARAMETERS
// - AW       32  address width
// - DW       32  data width
// - TIMEOUT  64  BUSY cycles without s_rdy before bus error (>=2)
// PORTS
// - clk       in   1   system clock
// - rst       in   1   reset, asynchronous, active-high
// - m0_ce     in   1   M0 request (level); held with addr/we/wdata until m0_rdy
// - m0_we     in   1   M0 write
// - m0_addr   in   AW  M0 address
// - m0_wdata  in   DW  M0 write data
// - m0_rdata  out  DW  M0 read data, valid while m0_rdy
// - m0_rdy    out  1   M0 completion, 1-cycle pulse
// - m0_err    out  1   M0 bus error, valid with m0_rdy
// - m1_*      ---  --  identical set for M1
// - s_ce      out  1   slave bus cycle active
// - s_we      out  1   slave write
// - s_addr    out  AW  slave address
// - s_wdata   out  DW  slave write data
// - s_rdata   in   DW  slave read data (decoder mux output)
// - s_rdy     in   1   slave ready, sampled only in BUSY
// - grant_id  out  1   owner of current or last transaction (debug/irq routing)
// BEHAVIOUR
// - Reset (async):
//   - state=IDLE; all outputs 0.
//   - last=1, so M0 wins the first tie.
//   - Timeout counter cleared. An in-flight slave cycle is abandoned; no rdy pulse is issued.
// - FSM:
//   - IDLE: if any mX_ce, latch winner's we/addr/wdata into s_* registers, set grant_id -> BUSY. Else stay.
//     Arbitration: a lone requester wins; if both request, the master != last wins.
//   - BUSY: s_ce=1 from s_* registers; cnt++ each cycle.
//     If s_rdy: latch s_rdata, err=0 -> DONE.
//     Else if cnt==TIMEOUT-1: rdata=0, err=1 -> DONE.
//   - DONE: s_ce=0; mG_rdy=1 for exactly 1 cycle with mG_rdata/mG_err; last<=G; cnt<=0 -> IDLE.
// - Latency: min 3 cycles ce->rdy (IDLE sample, BUSY with s_rdy=1, DONE). Each extra wait state adds 1.
// - Handshake:
//   - The master holds its request stable until it sees rdy.
//   - On the edge after rdy it drops ce or presents the next request; IDLE samples it fresh.
//   - Master inputs are ignored outside IDLE. Dropping ce mid-transaction does not abort the slave cycle.
// - Only the granted master sees rdy/err. The other master's rdy/err stay 0; its rdata is don't-care (drive 0).
// - s_addr/s_we/s_wdata hold stable for all of BUSY (registered, not muxed live).
// - Simultaneous requests: strict alternation, so continuous dual requests give M0,M1,M0,M1...
// - Timeout: counter width clog2(TIMEOUT). s_rdy arriving on the same cycle as the timeout compare wins (err=0).
// - Write completion: rdata=0, err=0 unless timed out.
// STRUCTURE
// - Package soc_bus_pkg:
//   - typedef enum logic[1:0] {ST_IDLE, ST_BUSY, ST_DONE} bus_state_t
//   - typedef logic master_id_t
//   - localparams M_CPU=0, M_DMA=1
// - Sub-module soc_rr_pick2: combinational winner = f(req[1:0], last). Reused by future IRQ arbitration.
// - Single always_ff with async rst for state/regs; outputs decoded from state.
// TESTING
// - Reset: rst=1 mid-BUSY (s_rdy=0) -> next cycle all outputs 0, state IDLE; no m*_rdy pulse ever for that cycle.
// - Single read: M0 ce, addr=FFFE0000, s_rdy=1, s_rdata=DEADBEEF -> s_ce high 1 cycle; m0_rdy pulse 3 cycles after ce; m0_rdata=DEADBEEF; m0_err=0.
// - Wait states: M1 write addr=F8000004 wdata=41; s_rdy after 5 BUSY cycles -> s_addr/s_wdata stable all 5 cycles; m1_rdy on 7th cycle; s_we=1.
// - Tie/round-robin: M0 and M1 request continuously from reset -> grant order M0,M1,M0,M1; grant_id toggles; no starvation over 20 transactions.
// - Timeout: TIMEOUT=8, s_rdy stuck 0 -> m0_rdy with m0_err=1, rdata=0 after exactly 8 BUSY cycles.
//   Repeat with s_rdy=1 on the 8th BUSY cycle -> err=0.
// - Back-to-back: M0 presents a new addr on the edge after rdy -> next transaction uses the new addr; the old addr is never reissued.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// Shared types for the SoC slave-bus arbiter: FSM states and master identifiers.
package soc_bus_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} bus_state_t;

    typedef logic master_id_t;

    localparam master_id_t M_CPU = 1'b0;
    localparam master_id_t M_DMA = 1'b1;

endpackage

// File: rtl/soc_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master that was not last.
module soc_rr_pick2
    import soc_bus_pkg::*;
(
    input  logic [1:0] i_req,
    input  master_id_t i_last,
    output master_id_t o_winner
);

    always_comb begin
        o_winner = M_CPU;
        if (i_req == 2'b11) begin
            o_winner = master_id_t'(~i_last);
        end else if (i_req[1]) begin
            o_winner = M_DMA;
        end
    end

endmodule

// File: rtl/soc_bus_arbiter.sv
// Shares the single SoC slave bus between the CPU (M0) and DMA/debug (M1), one transaction
// at a time, with slave wait states and a bus-error timeout.
module soc_bus_arbiter
    import soc_bus_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_ce,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rdy,
    output logic          m0_err,
    input  logic          m1_ce,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rdy,
    output logic          m1_err,
    output logic          s_ce,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_rdy,
    output logic          grant_id
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    bus_state_t    r_state;
    bus_state_t    w_next_state;
    master_id_t    r_grant;
    master_id_t    r_last;
    master_id_t    w_win;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_err;
    logic          w_timeout;
    logic          w_done;

    soc_rr_pick2 u_pick (
        .i_req    ({m1_ce, m0_ce}),
        .i_last   (r_last),
        .o_winner (w_win)
    );

    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (m0_ce || m1_ce) w_next_state = ST_BUSY;
            ST_BUSY: if (s_rdy || w_timeout) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Only the granted master sees the completion; the other side is held at zero.
    always_comb begin
        w_done   = (r_state == ST_DONE);
        s_ce     = (r_state == ST_BUSY);
        s_we     = r_we;
        s_addr   = r_addr;
        s_wdata  = r_wdata;
        grant_id = r_grant;
        m0_rdy   = w_done && (r_grant == M_CPU);
        m1_rdy   = w_done && (r_grant == M_DMA);
        m0_err   = m0_rdy && r_err;
        m1_err   = m1_rdy && r_err;
        m0_rdata = m0_rdy ? r_rdata : '0;
        m1_rdata = m1_rdy ? r_rdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= M_CPU;
            r_last  <= M_DMA;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (m0_ce || m1_ce) begin
                        r_grant <= w_win;
                        r_we    <= (w_win == M_DMA) ? m1_we    : m0_we;
                        r_addr  <= (w_win == M_DMA) ? m1_addr  : m0_addr;
                        r_wdata <= (w_win == M_DMA) ? m1_wdata : m0_wdata;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A ready arriving on the timeout cycle still completes cleanly.
                    if (s_rdy) begin
                        r_rdata <= r_we ? '0 : s_rdata;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_last <= r_grant;
                    r_cnt  <= '0;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Randomised bench for soc_bus_arbiter against a transaction-level reference model.
module tb_soc_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_ce, m0_we, m1_ce, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_rdy, m0_err, m1_rdy, m1_err;
    logic          s_ce, s_we, s_rdy;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic          grant_id;

    int checks   = 0;
    int failures = 0;
    logic exp_last = 1'b1;

    soc_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_ce(m0_ce), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_rdy(m0_rdy), .m0_err(m0_err),
        .m1_ce(m1_ce), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_rdy(m1_rdy), .m1_err(m1_err),
        .s_ce(s_ce), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_rdy(s_rdy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Reference arbitration: a lone requester wins, a tie goes to whoever was not last.
    function automatic logic model_pick(input logic c0, input logic c1, input logic last);
        if (c0 && c1) return !last;
        return c1;
    endfunction

    typedef struct {
        logic          done;
        int            busy_n;
        logic          stable;
        logic          stray;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          we;
        logic [1:0]    rdy;
        logic [1:0]    err;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        logic          gid;
    } obs_t;

    // Presents the master requests, plays the slave (ready on BUSY cycle rdy_at) and records what happened.
    task automatic drive_txn(input logic c0, input logic c1, input logic w0, input logic w1,
                             input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                             input int rdy_at, input logic [DW-1:0] srd, output obs_t o);
        int n;
        o = '{done: 1'b0, busy_n: 0, stable: 1'b1, stray: 1'b0, addr: '0, wdata: '0, we: 1'b0,
              rdy: 2'b00, err: 2'b00, rd0: '0, rd1: '0, gid: 1'b0};
        m0_ce = c0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_ce = c1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        s_rdy = 1'b0;
        n = 0;
        @(negedge clk);
        while (!s_ce && n < 6) begin
            if (m0_rdy || m1_rdy) o.stray = 1'b1;
            @(negedge clk);
            n++;
        end
        if (!s_ce) return;
        o.addr = s_addr; o.wdata = s_wdata; o.we = s_we;
        while (s_ce && o.busy_n < TO + 4) begin
            o.busy_n++;
            if (s_addr !== o.addr || s_wdata !== o.wdata || s_we !== o.we) o.stable = 1'b0;
            if (m0_rdy || m1_rdy) o.stray = 1'b1;
            s_rdy   = (o.busy_n == rdy_at);
            s_rdata = srd;
            @(negedge clk);
        end
        s_rdy   = 1'b0;
        s_rdata = $urandom;
        if (s_ce) return;
        o.done = 1'b1;
        o.rdy  = {m1_rdy, m0_rdy};
        o.err  = {m1_err, m0_err};
        o.rd0  = m0_rdata;
        o.rd1  = m1_rdata;
        o.gid  = grant_id;
    endtask

    task automatic idle_masters();
        m0_ce = 1'b0; m1_ce = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({s_ce, s_we, s_addr, s_wdata, m0_rdy, m0_err, m0_rdata, m1_rdy, m1_err, m1_rdata, grant_id} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got s_ce=%b s_addr=%h m0_rdy=%b m1_rdy=%b grant=%b want all zero",
                     s_ce, s_addr, m0_rdy, m1_rdy, grant_id);
        end
    endtask

    task automatic test_single_read();
        obs_t o;
        drive_txn(1, 0, 0, 0, 32'hFFFE_0000, '0, '0, '0, 1, 32'hDEAD_BEEF, o);
        exp_last = 1'b0;
        checks++;
        if (!o.done || o.busy_n != 1 || o.addr !== 32'hFFFE_0000 || o.we !== 1'b0) begin
            failures++;
            $display("FAIL single_read_bus: got done=%b busy=%0d addr=%h we=%b want 1 1 FFFE0000 0",
                     o.done, o.busy_n, o.addr, o.we);
        end
        checks++;
        if ({o.rdy, o.err, o.rd0, o.rd1, o.gid, o.stray} !== {2'b01, 2'b00, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL single_read_resp: got rdy=%b err=%b rd0=%h rd1=%h gid=%b stray=%b want 01 00 DEADBEEF 0 0 0",
                     o.rdy, o.err, o.rd0, o.rd1, o.gid, o.stray);
        end
        idle_masters();
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        obs_t o;
        drive_txn(0, 1, 0, 1, '0, 32'hF800_0004, '0, 32'h41, 5, 32'h1234_5678, o);
        exp_last = 1'b1;
        checks++;
        if (!o.done || o.busy_n != 5 || !o.stable || o.we !== 1'b1 || o.addr !== 32'hF800_0004 || o.wdata !== 32'h41) begin
            failures++;
            $display("FAIL wait_states_bus: got done=%b busy=%0d stable=%b we=%b addr=%h wdata=%h want 1 5 1 1 F8000004 41",
                     o.done, o.busy_n, o.stable, o.we, o.addr, o.wdata);
        end
        checks++;
        if ({o.rdy, o.err, o.rd1, o.rd0, o.gid, o.stray} !== {2'b10, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL wait_states_resp: got rdy=%b err=%b rd1=%h gid=%b stray=%b want 10 00 0 1 0",
                     o.rdy, o.err, o.rd1, o.gid, o.stray);
        end
        idle_masters();
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        obs_t o;
        int   cnt0 = 0;
        int   cnt1 = 0;
        int   bad  = 0;
        logic g;
        logic [AW-1:0] a0, a1;
        for (int i = 0; i < 20; i++) begin
            a0 = $urandom; a1 = $urandom;
            g = model_pick(1'b1, 1'b1, exp_last);
            drive_txn(1, 1, 0, 0, a0, a1, '0, '0, 1 + (i % 3), $urandom, o);
            exp_last = g;
            if (o.gid) cnt1++; else cnt0++;
            checks++;
            if (!o.done || o.gid !== g || o.addr !== (g ? a1 : a0) || o.rdy !== (g ? 2'b10 : 2'b01)) begin
                failures++;
                bad++;
                $display("FAIL round_robin[%0d]: got done=%b gid=%b addr=%h rdy=%b want gid=%b addr=%h",
                         i, o.done, o.gid, o.addr, o.rdy, g, g ? a1 : a0);
            end
        end
        checks++;
        if (cnt0 != 10 || cnt1 != 10) begin
            failures++;
            $display("FAIL round_robin_share: got m0=%0d m1=%0d want 10 10", cnt0, cnt1);
        end
        idle_masters();
        @(negedge clk);
    endtask

    task automatic test_timeout();
        obs_t o;
        drive_txn(1, 0, 0, 0, 32'h0000_1000, '0, '0, '0, TO + 5, 32'hCAFE_F00D, o);
        exp_last = 1'b0;
        checks++;
        if (!o.done || o.busy_n != TO || {o.rdy, o.err, o.rd0} !== {2'b01, 2'b01, 32'h0}) begin
            failures++;
            $display("FAIL timeout_err: got done=%b busy=%0d rdy=%b err=%b rd0=%h want 1 %0d 01 01 0",
                     o.done, o.busy_n, o.rdy, o.err, o.rd0, TO);
        end
        idle_masters();
        @(negedge clk);
        drive_txn(1, 0, 0, 0, 32'h0000_2000, '0, '0, '0, TO, 32'hCAFE_F00D, o);
        checks++;
        if (!o.done || o.busy_n != TO || {o.rdy, o.err, o.rd0} !== {2'b01, 2'b00, 32'hCAFE_F00D}) begin
            failures++;
            $display("FAIL timeout_edge_rdy: got done=%b busy=%0d rdy=%b err=%b rd0=%h want 1 %0d 01 00 CAFEF00D",
                     o.done, o.busy_n, o.rdy, o.err, o.rd0, TO);
        end
        idle_masters();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        obs_t o;
        drive_txn(1, 0, 0, 0, 32'hAAAA_0000, '0, '0, '0, 2, 32'h1111_1111, o);
        checks++;
        if (!o.done || o.addr !== 32'hAAAA_0000 || o.rd0 !== 32'h1111_1111) begin
            failures++;
            $display("FAIL b2b_first: got done=%b addr=%h rd0=%h want 1 AAAA0000 11111111", o.done, o.addr, o.rd0);
        end
        drive_txn(1, 0, 1, 0, 32'hBBBB_0004, '0, 32'h77, '0, 1, 32'h2222_2222, o);
        exp_last = 1'b0;
        checks++;
        if (!o.done || !o.stable || o.addr !== 32'hBBBB_0004 || o.we !== 1'b1 || o.wdata !== 32'h77 ||
            {o.rdy, o.err, o.rd0, o.stray} !== {2'b01, 2'b00, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_second: got done=%b addr=%h we=%b wdata=%h rdy=%b rd0=%h stray=%b want BBBB0004 1 77 01 0 0",
                     o.done, o.addr, o.we, o.wdata, o.rdy, o.rd0, o.stray);
        end
        idle_masters();
        @(negedge clk);
    endtask

    task automatic test_random();
        obs_t o;
        logic c0, c1, w0, w1, g, e, wg;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1, srd, exp_rd;
        int   ra, exp_busy;
        for (int i = 0; i < 30; i++) begin
            c0 = 1'($urandom); c1 = 1'($urandom);
            if (!c0 && !c1) c0 = 1'b1;
            w0 = 1'($urandom); w1 = 1'($urandom);
            a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom; srd = $urandom;
            ra = $urandom_range(1, TO + 2);
            g  = model_pick(c0, c1, exp_last);
            wg = g ? w1 : w0;
            e  = (ra > TO);
            exp_busy = e ? TO : ra;
            exp_rd   = (e || wg) ? 32'h0 : srd;
            drive_txn(c0, c1, w0, w1, a0, a1, d0, d1, ra, srd, o);
            exp_last = g;
            checks++;
            if (!o.done || o.busy_n != exp_busy || !o.stable || o.stray || o.gid !== g ||
                o.addr !== (g ? a1 : a0) || o.we !== wg || o.wdata !== (g ? d1 : d0) ||
                o.rdy !== (g ? 2'b10 : 2'b01) || o.err !== (e ? (g ? 2'b10 : 2'b01) : 2'b00) ||
                (g ? o.rd1 : o.rd0) !== exp_rd || (g ? o.rd0 : o.rd1) !== 32'h0) begin
                failures++;
                $display("FAIL random[%0d]: got gid=%b busy=%0d addr=%h we=%b rdy=%b err=%b rd0=%h rd1=%h want gid=%b busy=%0d addr=%h we=%b err=%b rd=%h",
                         i, o.gid, o.busy_n, o.addr, o.we, o.rdy, o.err, o.rd0, o.rd1,
                         g, exp_busy, g ? a1 : a0, wg, e, exp_rd);
            end
            if ($urandom_range(0, 2) == 0) begin
                idle_masters();
                @(negedge clk);
            end
        end
        idle_masters();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        obs_t o;
        int   n = 0;
        logic stray = 1'b0;
        m0_ce = 1'b1; m0_we = 1'b0; m0_addr = 32'h5555_0000;
        m1_ce = 1'b0; s_rdy = 1'b0;
        @(negedge clk);
        while (!s_ce && n < 6) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_ce !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_busy_start: got s_ce=%b want 1", s_ce);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_masters();
        exp_last = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_rdy = 1'b1;
            @(negedge clk);
            if (m0_rdy || m1_rdy || s_ce) stray = 1'b1;
        end
        s_rdy = 1'b0;
        checks++;
        if (stray !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_pulse: got stray=%b want 0", stray);
        end
        drive_txn(1, 1, 0, 0, 32'h0000_00A0, 32'h0000_00B0, '0, '0, 1, 32'h5A5A_5A5A, o);
        exp_last = 1'b0;
        checks++;
        if (!o.done || o.gid !== 1'b0 || o.addr !== 32'h0000_00A0) begin
            failures++;
            $display("FAIL reset_tie_m0: got done=%b gid=%b addr=%h want 1 0 000000A0", o.done, o.gid, o.addr);
        end
        idle_masters();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        m0_ce = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_ce = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        s_rdy = 0; s_rdata = '0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_read();
        test_wait_states();
        test_round_robin();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
